// File: rtl/core_trap_sequencer.sv
// Trap/xRET sequencer: on a trap it writes xEPC/xCAUSE/xTVAL, pushes the status stack
// and redirects fetch; on mret/sret it pops status and redirects to the saved EPC.
module core_trap_sequencer #(
  parameter int MEDELEG_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exception_valid,
  input  logic [4:0]  exception_cause,
  input  logic [31:0] exception_value,
  input  logic        m_interrupt_valid,
  input  logic [4:0]  m_interrupt_cause,
  input  logic        s_interrupt_valid,
  input  logic [4:0]  s_interrupt_cause,
  input  logic        mret,
  input  logic        sret,
  input  logic [31:0] pc,
  input  logic [1:0]  priv,
  input  logic [15:0] medeleg,
  input  logic [31:0] mtvec,
  input  logic [31:0] stvec,
  input  logic [31:0] mepc,
  input  logic [31:0] sepc,
  output logic        busy,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic [1:0]  status_op,
  output logic [1:0]  status_priv,
  output logic        pc_redirect_valid,
  output logic [31:0] pc_redirect_addr,
  input  logic        pc_redirect_ready,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    W_EPC      = 3'd1,
    W_CAUSE    = 3'd2,
    W_TVAL     = 3'd3,
    W_STATUS   = 3'd4,
    RET_STATUS = 3'd5,
    REDIRECT   = 3'd6
  } state_t;

  // idx 1/2/3 selects EPC/CAUSE/TVAL in the M (0x34x) or S (0x14x) bank
  function automatic logic [11:0] csr_addr(input logic smode, input logic [1:0] idx);
    return (smode ? 12'h140 : 12'h340) | {10'd0, idx};
  endfunction

  function automatic logic [1:0] priv_code(input logic smode);
    return smode ? 2'd1 : 2'd3;
  endfunction

  state_t      state_r;
  logic [4:0]  cause_r;
  logic [31:0] tval_r;
  logic        intr_r;
  logic        smode_r;
  logic [31:0] target_r;

  logic        sel_trap_s;
  logic        sel_ret_s;
  logic [4:0]  sel_cause_s;
  logic        sel_intr_s;
  logic [31:0] sel_tval_s;
  logic        sel_smode_s;
  logic [31:0] sel_tvec_s;
  logic [31:0] sel_base_s;
  logic [31:0] sel_target_s;

  // Request arbitration and trap target / redirect address computation
  always_comb begin
    sel_trap_s  = 1'b0;
    sel_ret_s   = 1'b0;
    sel_cause_s = 5'd0;
    sel_intr_s  = 1'b0;
    sel_tval_s  = 32'd0;
    sel_smode_s = 1'b0;
    if (m_interrupt_valid) begin
      sel_trap_s  = 1'b1;
      sel_cause_s = m_interrupt_cause;
      sel_intr_s  = 1'b1;
    end else if (s_interrupt_valid) begin
      sel_trap_s  = 1'b1;
      sel_cause_s = s_interrupt_cause;
      sel_intr_s  = 1'b1;
      sel_smode_s = 1'b1;
    end else if (exception_valid) begin
      sel_trap_s  = 1'b1;
      sel_cause_s = exception_cause;
      sel_tval_s  = exception_value;
      sel_smode_s = (MEDELEG_EN != 0) && (priv != 2'd3) && !exception_cause[4]
                    && medeleg[exception_cause[3:0]];
    end else if (mret) begin
      sel_ret_s = 1'b1;
    end else if (sret) begin
      sel_ret_s   = 1'b1;
      sel_smode_s = 1'b1;
    end else begin
      sel_trap_s = 1'b0;
    end

    sel_tvec_s = sel_smode_s ? stvec : mtvec;
    sel_base_s = {sel_tvec_s[31:2], 2'b00};
    if (sel_ret_s) begin
      sel_target_s = sel_smode_s ? sepc : mepc;
    end else if ((sel_tvec_s[1:0] == 2'b01) && sel_intr_s) begin
      sel_target_s = sel_base_s + {25'd0, sel_cause_s, 2'b00};
    end else begin
      sel_target_s = sel_base_s;
    end
  end

  // Sequencer FSM; every output is registered for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      cause_r           <= 5'd0;
      tval_r            <= 32'd0;
      intr_r            <= 1'b0;
      smode_r           <= 1'b0;
      target_r          <= 32'd0;
      busy              <= 1'b0;
      csr_wr_en         <= 1'b0;
      csr_wr_addr       <= 12'd0;
      csr_wr_data       <= 32'd0;
      status_op         <= 2'd0;
      status_priv       <= 2'd0;
      pc_redirect_valid <= 1'b0;
      pc_redirect_addr  <= 32'd0;
    end else begin
      csr_wr_en   <= 1'b0;
      csr_wr_addr <= 12'd0;
      csr_wr_data <= 32'd0;
      status_op   <= 2'd0;
      status_priv <= 2'd0;
      case (state_r)
        IDLE: begin
          cause_r  <= sel_cause_s;
          tval_r   <= sel_tval_s;
          intr_r   <= sel_intr_s;
          smode_r  <= sel_smode_s;
          target_r <= sel_target_s;
          if (sel_trap_s) begin
            state_r     <= W_EPC;
            busy        <= 1'b1;
            csr_wr_en   <= 1'b1;
            csr_wr_addr <= csr_addr(sel_smode_s, 2'd1);
            csr_wr_data <= pc;
          end else if (sel_ret_s) begin
            state_r     <= RET_STATUS;
            busy        <= 1'b1;
            status_op   <= 2'd2;
            status_priv <= priv_code(sel_smode_s);
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        W_EPC: begin
          state_r     <= W_CAUSE;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= csr_addr(smode_r, 2'd2);
          csr_wr_data <= {intr_r, 26'd0, cause_r};
        end
        W_CAUSE: begin
          state_r     <= W_TVAL;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= csr_addr(smode_r, 2'd3);
          csr_wr_data <= tval_r;
        end
        W_TVAL: begin
          state_r     <= W_STATUS;
          status_op   <= 2'd1;
          status_priv <= priv_code(smode_r);
        end
        W_STATUS, RET_STATUS: begin
          state_r           <= REDIRECT;
          pc_redirect_valid <= 1'b1;
          pc_redirect_addr  <= target_r;
        end
        REDIRECT: begin
          if (pc_redirect_ready) begin
            state_r           <= IDLE;
            busy              <= 1'b0;
            pc_redirect_valid <= 1'b0;
            pc_redirect_addr  <= 32'd0;
          end else begin
            state_r <= REDIRECT;
          end
        end
        default: begin
          state_r           <= IDLE;
          busy              <= 1'b0;
          pc_redirect_valid <= 1'b0;
          pc_redirect_addr  <= 32'd0;
        end
      endcase
    end
  end

  // The redirect is accepted in the very cycle ready is seen with valid high
  assign done = pc_redirect_valid & pc_redirect_ready;

endmodule

// File: tb/tb_core_trap_sequencer.sv
// Self-checking bench for core_trap_sequencer: directed vector table, hand-written
// handshake/reset sequences, then random traffic against a transaction-level model.
module tb_core_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exception_valid = 1'b0;
  logic [4:0]  exception_cause = 5'd0;
  logic [31:0] exception_value = 32'd0;
  logic        m_interrupt_valid = 1'b0;
  logic [4:0]  m_interrupt_cause = 5'd0;
  logic        s_interrupt_valid = 1'b0;
  logic [4:0]  s_interrupt_cause = 5'd0;
  logic        mret = 1'b0;
  logic        sret = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [1:0]  priv = 2'd0;
  logic [15:0] medeleg = 16'd0;
  logic [31:0] mtvec = 32'd0;
  logic [31:0] stvec = 32'd0;
  logic [31:0] mepc = 32'd0;
  logic [31:0] sepc = 32'd0;
  logic        busy;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [1:0]  status_op;
  logic [1:0]  status_priv;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_addr;
  logic        pc_redirect_ready = 1'b0;
  logic        done;

  int checks = 0;
  int errors = 0;

  core_trap_sequencer #(.MEDELEG_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .exception_valid(exception_valid), .exception_cause(exception_cause),
    .exception_value(exception_value),
    .m_interrupt_valid(m_interrupt_valid), .m_interrupt_cause(m_interrupt_cause),
    .s_interrupt_valid(s_interrupt_valid), .s_interrupt_cause(s_interrupt_cause),
    .mret(mret), .sret(sret), .pc(pc), .priv(priv), .medeleg(medeleg),
    .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
    .busy(busy), .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr),
    .csr_wr_data(csr_wr_data), .status_op(status_op), .status_priv(status_priv),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_addr(pc_redirect_addr),
    .pc_redirect_ready(pc_redirect_ready), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m_iv;
    logic [4:0]  m_c;
    logic        s_iv;
    logic [4:0]  s_c;
    logic        e_v;
    logic [4:0]  e_c;
    logic [31:0] e_val;
    logic        mret_v;
    logic        sret_v;
    logic [31:0] pc_v;
    logic [1:0]  priv_v;
    logic [15:0] medeleg_v;
    logic [31:0] mtvec_v;
    logic [31:0] stvec_v;
    logic [31:0] mepc_v;
    logic [31:0] sepc_v;
    logic        is_ret;
    logic [11:0] base;
    logic [31:0] cause_data;
    logic [31:0] tval;
    logic [1:0]  spriv;
    logic [31:0] redir;
  } vec_t;

  typedef struct {
    logic        busy;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  sop;
    logic [1:0]  spriv;
  } step_t;

  step_t       mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_redir = 32'd0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic b, input logic we, input logic [11:0] wa,
                         input logic [31:0] wd, input logic [1:0] so, input logic [1:0] sp,
                         input logic rv, input logic [31:0] ra, input logic dn);
    chk(nm, "busy", {31'd0, busy}, {31'd0, b});
    chk(nm, "csr_wr_en", {31'd0, csr_wr_en}, {31'd0, we});
    chk(nm, "csr_wr_addr", {20'd0, csr_wr_addr}, {20'd0, wa});
    chk(nm, "csr_wr_data", csr_wr_data, wd);
    chk(nm, "status_op", {30'd0, status_op}, {30'd0, so});
    chk(nm, "status_priv", {30'd0, status_priv}, {30'd0, sp});
    chk(nm, "redirect_valid", {31'd0, pc_redirect_valid}, {31'd0, rv});
    chk(nm, "redirect_addr", pc_redirect_addr, ra);
    chk(nm, "done", {31'd0, done}, {31'd0, dn});
  endtask

  task automatic chk_zero(input string nm);
    chk_all(nm, 1'b0, 1'b0, 12'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic clear_reqs();
    exception_valid = 1'b0; m_interrupt_valid = 1'b0; s_interrupt_valid = 1'b0;
    mret = 1'b0; sret = 1'b0;
  endtask

  // Change every data input so results can only come from captured copies
  task automatic scramble();
    pc = $urandom; mtvec = $urandom; stvec = $urandom; mepc = $urandom; sepc = $urandom;
    exception_value = $urandom; medeleg = 16'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    m_interrupt_valid = v.m_iv; m_interrupt_cause = v.m_c;
    s_interrupt_valid = v.s_iv; s_interrupt_cause = v.s_c;
    exception_valid = v.e_v; exception_cause = v.e_c; exception_value = v.e_val;
    mret = v.mret_v; sret = v.sret_v; pc = v.pc_v; priv = v.priv_v; medeleg = v.medeleg_v;
    mtvec = v.mtvec_v; stvec = v.stvec_v; mepc = v.mepc_v; sepc = v.sepc_v;
    pc_redirect_ready = 1'b1;
    #2 chk_zero("vec_accept");
    @(negedge clk); clear_reqs(); scramble();
    #2;
    if (!v.is_ret) begin
      chk_all("vec_epc", 1'b1, 1'b1, v.base + 12'h041, v.pc_v, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk); #2;
      chk_all("vec_cause", 1'b1, 1'b1, v.base + 12'h042, v.cause_data, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk); #2;
      chk_all("vec_tval", 1'b1, 1'b1, v.base + 12'h043, v.tval, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk); #2;
      chk_all("vec_status", 1'b1, 1'b0, 12'd0, 32'd0, 2'd1, v.spriv, 1'b0, 32'd0, 1'b0);
    end else begin
      chk_all("vec_ret", 1'b1, 1'b0, 12'd0, 32'd0, 2'd2, v.spriv, 1'b0, 32'd0, 1'b0);
    end
    @(negedge clk); #2;
    chk_all("vec_redirect", 1'b1, 1'b0, 12'd0, 32'd0, 2'd0, 2'd0, 1'b1, v.redir, 1'b1);
    @(negedge clk); #2;
    chk_zero("vec_after");
  endtask

  // Reference: on acceptance, a transaction expands into its list of per-cycle outputs
  task automatic model_accept();
    logic [4:0]  c;
    logic        intr;
    logic        smode;
    logic [31:0] tv;
    logic [31:0] tvec;
    logic [11:0] sb;
    logic        trap;
    trap = 1'b1; intr = 1'b1; smode = 1'b0; c = 5'd0; tv = 32'd0;
    if (m_interrupt_valid) c = m_interrupt_cause;
    else if (s_interrupt_valid) begin c = s_interrupt_cause; smode = 1'b1; end
    else if (exception_valid) begin
      c = exception_cause; intr = 1'b0; tv = exception_value;
      smode = (priv != 2'd3) && (exception_cause < 5'd16) && (((medeleg >> exception_cause) & 16'd1) != 16'd0);
    end else if (mret) begin
      trap = 1'b0;
      mq.push_back('{1'b1, 1'b0, 12'd0, 32'd0, 2'd2, 2'd3});
      m_redir = mepc; m_pend = 1'b1;
    end else if (sret) begin
      trap = 1'b0;
      mq.push_back('{1'b1, 1'b0, 12'd0, 32'd0, 2'd2, 2'd1});
      m_redir = sepc; m_pend = 1'b1;
    end else trap = 1'b0;
    if (trap) begin
      sb = smode ? 12'h100 : 12'h300;
      mq.push_back('{1'b1, 1'b1, sb + 12'h041, pc, 2'd0, 2'd0});
      mq.push_back('{1'b1, 1'b1, sb + 12'h042, (32'(intr) << 31) + 32'(c), 2'd0, 2'd0});
      mq.push_back('{1'b1, 1'b1, sb + 12'h043, intr ? 32'd0 : tv, 2'd0, 2'd0});
      mq.push_back('{1'b1, 1'b0, 12'd0, 32'd0, 2'd1, smode ? 2'd1 : 2'd3});
      tvec = smode ? stvec : mtvec;
      m_redir = (tvec & 32'hFFFF_FFFC) + (((tvec % 32'd4) == 32'd1 && intr) ? 32'd4 * 32'(c) : 32'd0);
      m_pend = 1'b1;
    end
  endtask

  vec_t vecs[9];

  initial begin
    step_t s;
    vecs[0] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'hDEAD, 1'b0, 1'b0, 32'h100, 2'd0, 16'h0004,
                32'h0, 32'h8000_1001, 32'h0, 32'h0, 1'b0, 12'h100, 32'd2, 32'hDEAD, 2'd1, 32'h8000_1000};
    vecs[1] = '{1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd2, 32'h1111, 1'b0, 1'b0, 32'h2000, 2'd3, 16'h0004,
                32'h201, 32'h0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h8000_0007, 32'h0, 2'd3, 32'h21C};
    vecs[2] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'hBEEF, 1'b0, 1'b0, 32'h3000, 2'd3, 16'h0004,
                32'h1000, 32'h5000, 32'h0, 32'h0, 1'b0, 12'h300, 32'd2, 32'hBEEF, 2'd3, 32'h1000};
    vecs[3] = '{1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h4444, 2'd0, 16'h0,
                32'h9000, 32'h3001, 32'h7000, 32'h0, 1'b0, 12'h100, 32'h8000_0005, 32'h0, 2'd1, 32'h3014};
    vecs[4] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd20, 32'h55, 1'b0, 1'b0, 32'h600, 2'd0, 16'hFFFF,
                32'h501, 32'h8000, 32'h0, 32'h0, 1'b0, 12'h300, 32'd20, 32'h55, 2'd3, 32'h500};
    vecs[5] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h66, 1'b0, 1'b0, 32'h700, 2'd1, 16'h0004,
                32'h800, 32'h900, 32'h0, 32'h0, 1'b0, 12'h300, 32'd3, 32'h66, 2'd3, 32'h800};
    vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h0, 2'd3, 16'h0,
                32'h0, 32'h0, 32'h4000, 32'h8888, 1'b1, 12'h0, 32'h0, 32'h0, 2'd3, 32'h4000};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 2'd1, 16'h0,
                32'h0, 32'h0, 32'h1, 32'h1234_5678, 1'b1, 12'h0, 32'h0, 32'h0, 2'd1, 32'h1234_5678};
    vecs[8] = '{1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'hABC, 2'd0, 16'h0,
                32'hFFFF_FFFD, 32'h0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h8000_001F, 32'h0, 2'd3, 32'h78};

    #2 chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    #2 chk_zero("idle");

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // mret with a stalled fetch: redirect must hold, done pulses once
    @(negedge clk); mret = 1'b1; mepc = 32'h4000; pc_redirect_ready = 1'b0;
    #2 chk_zero("stall_accept");
    @(negedge clk); clear_reqs(); scramble();
    #2 chk_all("stall_status", 1'b1, 1'b0, 12'd0, 32'd0, 2'd2, 2'd3, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk_all("stall_hold", 1'b1, 1'b0, 12'd0, 32'd0, 2'd0, 2'd0, 1'b1, 32'h4000, 1'b0);
    end
    @(negedge clk); pc_redirect_ready = 1'b1;
    #2 chk_all("stall_done", 1'b1, 1'b0, 12'd0, 32'd0, 2'd0, 2'd0, 1'b1, 32'h4000, 1'b1);
    @(negedge clk); #2 chk_zero("stall_after");

    // Reset while writing CAUSE, then an sret after release
    @(negedge clk); exception_valid = 1'b1; exception_cause = 5'd2; priv = 2'd3;
    medeleg = 16'h0; mtvec = 32'h100; pc = 32'h55;
    @(negedge clk); clear_reqs();
    #2 chk_all("rst_epc", 1'b1, 1'b1, 12'h341, 32'h55, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #2;
    chk_all("rst_cause", 1'b1, 1'b1, 12'h342, 32'd2, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk); #2 chk_zero("rst_hold");
    @(negedge clk); rst_n = 1'b1; sret = 1'b1; sepc = 32'h9ABC;
    #2 chk_zero("rst_release");
    @(negedge clk); clear_reqs(); scramble();
    #2 chk_all("rst_sret_status", 1'b1, 1'b0, 12'd0, 32'd0, 2'd2, 2'd1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #2;
    chk_all("rst_sret_redirect", 1'b1, 1'b0, 12'd0, 32'd0, 2'd0, 2'd0, 1'b1, 32'h9ABC, 1'b1);
    @(negedge clk); #2 chk_zero("rst_after");

    // Random traffic against the transaction model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      m_interrupt_valid = ($urandom_range(0, 7) == 0);
      s_interrupt_valid = ($urandom_range(0, 7) == 0);
      exception_valid   = ($urandom_range(0, 3) == 0);
      mret = ($urandom_range(0, 7) == 0);
      sret = ($urandom_range(0, 7) == 0);
      m_interrupt_cause = 5'($urandom_range(0, 31));
      s_interrupt_cause = 5'($urandom_range(0, 31));
      exception_cause   = 5'($urandom_range(0, 31));
      priv = 2'($urandom_range(0, 3));
      scramble();
      if ($urandom_range(0, 1) == 0) begin
        mtvec = (mtvec & 32'hFFFF_FFFC) | 32'd1;
        stvec = (stvec & 32'hFFFF_FFFC) | 32'd1;
      end
      pc_redirect_ready = ($urandom_range(0, 1) == 0);
      #2;
      if (!rst_n) begin
        chk_zero("rnd_reset");
        mq.delete(); m_pend = 1'b0;
      end else if (mq.size() > 0) begin
        s = mq.pop_front();
        chk_all("rnd_step", s.busy, s.wen, s.waddr, s.wdata, s.sop, s.spriv, 1'b0, 32'd0, 1'b0);
      end else if (m_pend) begin
        chk_all("rnd_redirect", 1'b1, 1'b0, 12'd0, 32'd0, 2'd0, 2'd0, 1'b1, m_redir, pc_redirect_ready);
        if (pc_redirect_ready) m_pend = 1'b0;
      end else begin
        chk_zero("rnd_idle");
        model_accept();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
